// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV64 load/store unit with read-modify-write for narrow stores
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [63:0] address,
  input  logic [63:0] store_data,
  output logic [63:0] load_data,
  output logic        stall,
  output logic        access_error,
  output logic        dm_read,
  output logic        dm_write,
  output logic [63:0] dm_address,
  output logic [63:0] dm_write_data,
  input  logic [63:0] dm_read_data
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] held_word;

  logic [5:0]  shamt;
  logic [63:0] size_mask;
  logic [63:0] lane_mask;
  logic [63:0] lane;
  logic [63:0] merged;
  logic        misaligned;
  logic        bad_funct3;
  logic        err;
  logic        narrow_store;

  // Memory is always addressed on the containing doubleword.
  assign dm_address = {address[63:3], 3'b000};
  assign shamt      = {address[2:0], 3'b000};

  // Decode access size, alignment, error conditions, load lane and store merge.
  always_comb begin
    size_mask  = '1;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: size_mask = 64'h0000_0000_0000_00FF;
      2'b01: begin
        size_mask  = 64'h0000_0000_0000_FFFF;
        misaligned = address[0];
      end
      2'b10: begin
        size_mask  = 64'h0000_0000_FFFF_FFFF;
        misaligned = |address[1:0];
      end
      2'b11: begin
        size_mask  = '1;
        misaligned = |address[2:0];
      end
    endcase
    lane_mask    = size_mask << shamt;
    lane         = dm_read_data >> shamt;
    merged       = (held_word & ~lane_mask) | ((store_data << shamt) & lane_mask);
    bad_funct3   = (mem_read && (funct3 == 3'b111)) || (mem_write && funct3[2]);
    err          = (mem_read && mem_write) || ((mem_read || mem_write) && misaligned) || bad_funct3;
    narrow_store = mem_write && !err && (funct3[1:0] != 2'b11);
  end

  // Next state and memory/pipeline outputs; reset suppresses every request, including a pending write.
  always_comb begin
    state_next    = state;
    load_data     = '0;
    stall         = 1'b0;
    access_error  = 1'b0;
    dm_read       = 1'b0;
    dm_write      = 1'b0;
    dm_write_data = '0;
    if (!rst_n) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          access_error = err;
          if (!err && mem_read) begin
            dm_read = 1'b1;
            case (funct3)
              3'b000:  load_data = {{56{lane[7]}}, lane[7:0]};
              3'b001:  load_data = {{48{lane[15]}}, lane[15:0]};
              3'b010:  load_data = {{32{lane[31]}}, lane[31:0]};
              3'b011:  load_data = lane;
              3'b100:  load_data = {56'b0, lane[7:0]};
              3'b101:  load_data = {48'b0, lane[15:0]};
              3'b110:  load_data = {32'b0, lane[31:0]};
              default: load_data = '0;
            endcase
          end else if (!err && mem_write) begin
            if (narrow_store) begin
              dm_read    = 1'b1;
              stall      = 1'b1;
              state_next = WRITE;
            end else begin
              dm_write      = 1'b1;
              dm_write_data = store_data;
            end
          end
        end
        WRITE: begin
          dm_write      = 1'b1;
          dm_write_data = merged;
          state_next    = IDLE;
        end
      endcase
    end
  end

  // State register; the fetched word is captured on the read half of a narrow store.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      held_word <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && narrow_store) begin
        held_word <= dm_read_data;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the MEM pipeline stage and `data_memory`. It turns RV64 load/store requests (byte, half, word, double; signed or unsigned) into 64-bit aligned word accesses. Loads are extracted and sign- or zero-extended in the same cycle. Sub-doubleword stores are done as a two-cycle read-modify-write, with a stall back to the pipeline. Misaligned or illegal accesses are flagged and never reach memory.

## Interface
- No parameters; data and address width fixed at 64.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `mem_read`  in  1  load request from MEM stage.
- `mem_write`  in  1  store request from MEM stage.
- `funct3`  in  3  access size and sign:
  - loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
  - stores: 000 sb, 001 sh, 010 sw, 011 sd
- `address`  in  64  byte address.
- `store_data`  in  64  store operand; the low bytes are used.
- `load_data`  out  64  extended load result.
- `stall`  out  1  pipeline must hold MEM-stage inputs stable next cycle.
- `access_error`  out  1  misaligned access, illegal funct3, or read and write both high.
- `dm_read`  out  1  to `data_memory.mem_read`.
- `dm_write`  out  1  to `data_memory.mem_write`.
- `dm_address`  out  64  `{address[63:3],3'b000}`.
- `dm_write_data`  out  64  full word to write.
- `dm_read_data`  in  64  from `data_memory.read_data`; asynchronous, 0 when `dm_read`=0.

## Operation
- **State machine:** IDLE and WRITE only.
- **Registered state:**
  - state register
  - 64-bit merge register `held_word`, which captures the fetched word
- **Alignment:**
  - size = 1 << funct3[1:0]
  - misaligned when `address[2:0]` is not a multiple of size
- **Error cases:** `access_error`=1 combinationally in any of these cases:
  - misaligned access
  - load funct3 = 111
  - store funct3[2] = 1
  - `mem_read` && `mem_write`
  
  On error: `dm_read`=`dm_write`=0, `stall`=0, `load_data`=0, state stays IDLE.
- **Load (IDLE, no error):**
  - `dm_read`=1.
  - Lane = `dm_read_data >> (8*address[2:0])`, truncated to size.
  - Sign-extend if funct3[2]=0, else zero-extend.
  - Completes the same cycle; `stall`=0.
- **sd (IDLE, no error):** `dm_write`=1, `dm_write_data`=`store_data`, `stall`=0; single cycle.
- **sb/sh/sw, IDLE cycle:**
  - `dm_read`=1, `stall`=1.
  - At the clock edge, `held_word` <= `dm_read_data` and state -> WRITE.
- **sb/sh/sw, WRITE cycle:**
  - `dm_write`=1, `stall`=0.
  - `dm_write_data` = `held_word` with the size-byte lane at `address[2:0]` replaced by the low bytes of `store_data`.
  - Inputs are guaranteed unchanged, because the pipeline held them while `stall` was 1.
  - At the edge, state -> IDLE.
- **Outputs when idle:** with no request, `load_data`=0, `dm_read`=`dm_write`=0, `dm_write_data`=0.
- **Address range:** `dm_address` passes through unmodified above bit 3. Wrap above 4 KiB is the memory's indexing behaviour, not handled here.

## Timing
- **Reset:** while `rst_n`=0, `dm_read`, `dm_write`, `stall`, `access_error` and `load_data` are forced to 0. At the edge, state <= IDLE and `held_word` <= 0.
- **Reset mid-RMW:** if `rst_n`=0 during the WRITE cycle, no write is issued and memory is unchanged.
- **Latencies:**
  - loads and sd: 0 extra cycles
  - sb/sh/sw: exactly 1 stall cycle, 2 cycles total
- **WRITE cycle:** `mem_read`/`mem_write` are ignored for new decoding; the held request is completed.
- **Back-to-back stores to the same word:** the second request's read happens after the first write's edge, so it sees the merged data. No forwarding is needed.
- **Loads after a store:** a load in the cycle after any store's write edge returns the new data.

## Test plan
- **ld:** memory word1=20; ld `address`=0x8 -> `load_data`=0x14, `dm_read`=1, `stall`=0, `access_error`=0.
- **sd then narrow loads:**
  - sd 0x10 with data 0x000000000000FF80, then lb 0x10 -> 0xFFFFFFFFFFFFFF80.
  - lbu 0x11 -> 0xFF.
  - lh 0x10 -> 0xFFFFFFFFFFFFFF80.
  - lwu 0x10 -> 0xFF80.
- **sb 0x9 with data 0xAB** (word1=0x14):
  - cycle 0: `stall`=1, `dm_read`=1.
  - cycle 1: `dm_write`=1, `dm_write_data`=0x000000000000AB14, `stall`=0.
  - ld 0x8 afterwards -> 0xAB14.
- **Back-to-back sb** (word0=0x0A): sb 0x0 with 0xAB, then sb 0x1 with 0xCD -> ld 0x0 returns 0xCDAB. Total 4 cycles.
- **Errors:**
  - lw 0x6 -> `access_error`=1, `dm_read`=0.
  - sh 0x3 -> `access_error`=1, `dm_write`=0 both cycles, word0 unchanged.
  - load funct3=111 -> `access_error`=1.
  - both `mem_read` and `mem_write` high -> `access_error`=1.
- **Reset during RMW:** sh 0x10 with 0x1234; drop `rst_n` in the WRITE cycle -> `dm_write`=0, word2 unchanged, `stall`=0. After release, state IDLE and the next ld works.
